div_ctrl: RTL and testbench

- Multi-cycle iterative divide sequencer in the EX stage of the 5-stage MIPS pipeline.
- Accepts DIV/DIVU operands from E and runs a radix-2 restoring divide, one quotient bit per cycle.
- Holds the pipeline through a stall request merged into the hazard unit's stallF/stallD/flushE logic.
- Delivers {HI=remainder, LO=quotient} to the HI/LO write path with a one-cycle ready pulse.

---
 rtl/mips_div_pkg.sv | 21 ++
 rtl/div_step.sv | 25 ++
 rtl/div_ctrl.sv | 139 +++++++++++++
 tb/tb_div_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// rtl/mips_div_pkg.sv - shared types and constants for the iterative divide sequencer
package mips_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = {DIV_WIDTH{1'b1}};

    // result_o layout: HI (remainder) in the upper half, LO (quotient) in the lower half
    localparam int RES_LO_LSB = 0;
    localparam int RES_LO_MSB = DIV_WIDTH - 1;
    localparam int RES_HI_LSB = DIV_WIDTH;
    localparam int RES_HI_MSB = 2 * DIV_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring divide iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] sreg_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] sreg_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           qbit;

    // rem < div on entry, so a non-negative trial always fits in WIDTH bits
    always_comb begin
        shifted = {rem_i, sreg_i[WIDTH-1]};
        trial   = shifted - {1'b0, div_i};
        qbit    = ~trial[WIDTH];
        rem_o   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        sreg_o  = {sreg_i[WIDTH-2:0], qbit};
    end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - EX-stage iterative DIV/DIVU sequencer with pipeline stall and HI/LO result
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |a| < |b|.
module div_ctrl
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               annul_i,
    output logic               stall_o,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);

    div_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   step_rem, step_sreg;
    logic [WIDTH-1:0]   fix_q, fix_r;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .sreg_i (sreg_q),
        .div_i  (div_q),
        .rem_o  (step_rem),
        .sreg_o (step_sreg)
    );

    always_comb begin
        abs_a = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
        abs_b = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
        fix_q = neg_q_q ? -step_sreg : step_sreg;
        fix_r = neg_r_q ? -step_rem  : step_rem;

        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        sreg_d   = sreg_q;
        div_d    = div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    rem_d   = '0;
                    sreg_d  = abs_a;
                    div_d   = abs_b;
                    cnt_d   = '0;
                    neg_q_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    neg_r_d = signed_i & a_i[WIDTH-1];
                    if (b_i == '0) begin
                        state_d  = S_DONE;
                        result_d = {a_i, {WIDTH{1'b1}}};
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (abs_a < abs_b) begin
                        state_d  = S_DONE;
                        result_d = {a_i, {WIDTH{1'b0}}};
                    end
`endif
                    else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                rem_d  = step_rem;
                sreg_d = step_sreg;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    result_d = {fix_r, fix_q};
                end
            end
            // start_i here still belongs to the instruction that is completing
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (annul_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end

        ready_d = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            sreg_q   <= '0;
            div_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            sreg_q   <= sreg_d;
            div_q    <= div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign stall_o  = !annul_i && ((state_q == S_IDLE && start_i) || state_q == S_BUSY);
    assign busy_o   = busy_q;
    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl (honours DIV_EARLY_OUT_EN)
module tb_div_ctrl;
    import mips_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        stall_o, busy_o, ready_o;
    logic [63:0] result_o;

    int checks = 0;
    int errors = 0;

    int          r_cyc, s_last, s_cnt;
    logic [63:0] r_res;

    always #5 clk = ~clk;

    div_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .annul_i  (annul_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .ready_o  (ready_o),
        .result_o (result_o)
    );

    // Called right after a rising edge; that cycle is cycle 0. Start is held until ready.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        r_cyc = -1; s_last = -1; s_cnt = 0; r_res = '0;
        signed_i = sg; a_i = a; b_i = b; start_i = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (stall_o) begin s_last = c; s_cnt++; end
            if (ready_o) begin r_cyc = c; r_res = result_o; end
            @(posedge clk); #1;
            a_i = ~a;
            b_i = b ^ 32'h5a5a_0001;
            if (r_cyc >= 0) break;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", ready_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall_o); end
        checks++; if (result_o !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_divu();
        run_div(1'b0, 32'd100, 32'd7);
        checks++; if (r_cyc != 33) begin errors++; $display("FAIL divu_ready_cycle got %0d want 33", r_cyc); end
        checks++; if (s_last != 32 || s_cnt != 33) begin errors++; $display("FAIL divu_stall got last %0d count %0d want 32/33", s_last, s_cnt); end
        checks++; if (r_res !== {32'h2, 32'hE}) begin errors++; $display("FAIL divu_100_7 got %h want %h", r_res, {32'h2, 32'hE}); end
        @(negedge clk);
        checks++; if (ready_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL divu_after got ready %0b busy %0b want 0 0", ready_o, busy_o); end
        checks++; if (result_o !== {32'h2, 32'hE}) begin errors++; $display("FAIL divu_hold got %h want %h", result_o, {32'h2, 32'hE}); end
        @(posedge clk); #1;
        run_div(1'b0, 32'hFFFF_FFFF, 32'h10);
        checks++; if (r_res[RES_LO_MSB:RES_LO_LSB] !== 32'h0FFF_FFFF || r_res[RES_HI_MSB:RES_HI_LSB] !== 32'hF) begin
            errors++; $display("FAIL divu_max got %h want %h", r_res, {32'hF, 32'h0FFF_FFFF}); end
    endtask

    task automatic test_signed();
        run_div(1'b1, 32'hFFFF_FFF9, 32'h2);
        checks++; if (r_res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_m7_2 got %h want %h", r_res, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
        run_div(1'b1, 32'h7, 32'hFFFF_FFFE);
        checks++; if (r_res !== {32'h1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_7_m2 got %h want %h", r_res, {32'h1, 32'hFFFF_FFFD}); end
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++; if (r_res !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_min_m1 got %h want %h", r_res, {32'h0, 32'h8000_0000}); end
        checks++; if (r_cyc != 33) begin errors++; $display("FAIL div_signed_ready_cycle got %0d want 33", r_cyc); end
    endtask

    task automatic test_div_zero();
        run_div(1'b0, 32'h1234, 32'h0);
        checks++; if (r_cyc != 1) begin errors++; $display("FAIL div0_ready_cycle got %0d want 1", r_cyc); end
        checks++; if (s_last != 0 || s_cnt != 1) begin errors++; $display("FAIL div0_stall got last %0d count %0d want 0/1", s_last, s_cnt); end
        checks++; if (r_res !== {32'h1234, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div0_unsigned got %h want %h", r_res, {32'h1234, 32'hFFFF_FFFF}); end
        run_div(1'b1, 32'hFFFF_FFF0, 32'h0);
        checks++; if (r_res !== {32'hFFFF_FFF0, DIV0_QUOT}) begin errors++; $display("FAIL div0_signed got %h want %h", r_res, {32'hFFFF_FFF0, DIV0_QUOT}); end
    endtask

    task automatic test_annul();
        logic [63:0] prev;
        int          spurious, rdy_abs;
        prev = result_o; spurious = 0; rdy_abs = -1;
        signed_i = 1'b1; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready_o) spurious++;
            @(posedge clk); #1;
        end
        annul_i = 1'b1; #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL annul_stall got %0b want 0", stall_o); end
        @(posedge clk); #1;
        annul_i = 1'b0; start_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || ready_o !== 1'b0) begin errors++; $display("FAIL annul_idle got busy %0b ready %0b want 0 0", busy_o, ready_o); end
        checks++; if (result_o !== prev) begin errors++; $display("FAIL annul_result got %h want %h", result_o, prev); end
        signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
        for (int c = 11; c < 80; c++) begin
            @(negedge clk);
            if (ready_o) begin rdy_abs = c; r_res = result_o; end
            @(posedge clk); #1;
            if (rdy_abs >= 0) break;
        end
        start_i = 1'b0;
        checks++; if (spurious != 0) begin errors++; $display("FAIL annul_no_ready got %0d pulses want 0", spurious); end
        checks++; if (rdy_abs != 44) begin errors++; $display("FAIL annul_restart_cycle got %0d want 44", rdy_abs); end
        checks++; if (r_res !== {32'h1, 32'd333}) begin errors++; $display("FAIL annul_restart_result got %h want %h", r_res, {32'h1, 32'd333}); end
        start_i = 1'b1; annul_i = 1'b1; #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL annul_start_stall got %0b want 0", stall_o); end
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL annul_start_busy got %0b want 0", busy_o); end
    endtask

    task automatic test_reset_mid();
        signed_i = 1'b0; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        for (int c = 0; c < 15; c++) @(posedge clk);
        #1;
        rst = 1'b1; start_i = 1'b0; #2;
        checks++; if (busy_o !== 1'b0 || ready_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ctrl got busy %0b ready %0b stall %0b want 0 0 0", busy_o, ready_o, stall_o); end
        checks++; if (result_o !== 64'h0) begin errors++; $display("FAIL rst_mid_result got %h want 0", result_o); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        t0 = $time;
        run_div(1'b0, 32'd9, 32'd3);
        checks++; if (r_cyc != 33 || r_res !== {32'h0, 32'h3}) begin errors++; $display("FAIL b2b_first got cycle %0d res %h want 33 %h", r_cyc, r_res, {32'h0, 32'h3}); end
        t1 = $time;
        run_div(1'b0, 32'd10, 32'd4);
        checks++; if ((t1 - t0) / 10 + r_cyc != 67) begin errors++; $display("FAIL b2b_second_cycle got %0d want 67", (t1 - t0) / 10 + r_cyc); end
        checks++; if (r_res !== {32'h2, 32'h2}) begin errors++; $display("FAIL b2b_second got %h want %h", r_res, {32'h2, 32'h2}); end
    endtask

    task automatic test_early_out();
        int exp_cyc;
`ifdef DIV_EARLY_OUT_EN
        exp_cyc = 1;
`else
        exp_cyc = 33;
`endif
        run_div(1'b0, 32'd3, 32'd10);
        checks++; if (r_cyc != exp_cyc) begin errors++; $display("FAIL early_ready_cycle got %0d want %0d", r_cyc, exp_cyc); end
        checks++; if (s_cnt != exp_cyc) begin errors++; $display("FAIL early_stall_count got %0d want %0d", s_cnt, exp_cyc); end
        checks++; if (r_res !== {32'h3, 32'h0}) begin errors++; $display("FAIL early_3_10 got %h want %h", r_res, {32'h3, 32'h0}); end
        run_div(1'b1, 32'hFFFF_FFFD, 32'd10);
        checks++; if (r_res !== {32'hFFFF_FFFD, 32'h0}) begin errors++; $display("FAIL early_m3_10 got %h want %h", r_res, {32'hFFFF_FFFD, 32'h0}); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        test_early_out();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
